// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 inverse cipher (FIPS-197 InvCipher), one round per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data ciphertext in;
//        rk_idx/rk round-key lookup; out_valid/out_ready/out_data plaintext out;
//        abort only when INV_CIPHER_ABORT_EN is defined.
// Byte i of every 128-bit word is [127-8i -: 8], column-major (row i%4, col i/4).
module inv_cipher_iter (
    input  logic         clk,
    input  logic         rst,
`ifdef INV_CIPHER_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [1:0]   r_state;
    logic [3:0]   r_cnt;
    logic [127:0] r_st;
    logic [127:0] r_out;

    logic [127:0] w_isr;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_imc;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    // Output row r, column c takes input row r, column (c - r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] =
                    s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column times the {0e,0b,0d,09} circulant; multiples built from x2/x4/x8.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // One shared datapath: ROUND takes w_imc, FINAL takes w_ark.
    assign w_isr = inv_shift_rows(r_st);
    assign w_isb = inv_sub_bytes(w_isr);
    assign w_ark = w_isb ^ rk;
    assign w_imc = inv_mix_columns(w_ark);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_out;

    always_comb begin
        rk_idx = 4'd0;
        case (r_state)
            S_IDLE:  rk_idx = 4'd10;
            S_ROUND: rk_idx = r_cnt;
            S_FINAL: rk_idx = 4'd0;
            default: rk_idx = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_st    <= '0;
            r_out   <= '0;
        end
`ifdef INV_CIPHER_ABORT_EN
        else if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
        end
`endif
        else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_st    <= in_data ^ rk;
                        r_cnt   <= 4'd9;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_st <= w_imc;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_FINAL;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_FINAL: begin
                    r_out   <= w_ark;
                    r_state <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
